// File: rtl/fp_pkg.sv
// +----------------------------------------------------------------------+
// | fp_pkg                                                               |
// | Shared types and constants for the sequential FP32 add/sub block.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        PACK   = 3'd5,
        HOLD   = 3'd6
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int          BIAS    = 127;

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// +----------------------------------------------------------------------+
// | fp_lzc                                                               |
// | Combinational leading-zero counter; all-zero input returns WIDTH.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_lzc #(
    parameter int WIDTH = 28,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [CW-1:0]    o_count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_value[i]) o_count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_seq.sv
// +----------------------------------------------------------------------+
// | fp_addsub_seq                                                        |
// | Multi-cycle IEEE-754 single add/sub, truncating, fixed 5-cycle       |
// | latency. Optional inf/NaN handling: define FP_ADDSUB_SPECIAL_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int GUARD = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    localparam int         c_SIG_W     = 24 + GUARD;
    localparam int         c_NRM_W     = c_SIG_W + 1;
    localparam int         c_CW        = $clog2(c_NRM_W + 1);
    localparam logic [7:0] c_SHIFT_MAX = 8'(c_SIG_W);

    state_t r_state, w_next_state;

    logic [31:0]             r_a, r_b;
    logic                    r_op;
    logic                    r_sa, r_sb;
    logic [7:0]              r_ea, r_eb;
    logic [23:0]             r_ma, r_mb;
    logic                    r_sx, r_sy;
    logic [7:0]              r_ex;
    logic [c_SIG_W-1:0]      r_sigx, r_sigy;
    logic                    r_rs;
    logic [7:0]              r_rexp;
    logic [c_NRM_W-1:0]      r_sum;
    logic [c_NRM_W-1:0]      r_nsig;
    logic signed [9:0]       r_nexp;
    logic                    r_nzero;
    logic [31:0]             r_result;
    logic [2:0]              r_flags;

    fp32_t w_fa, w_fb;
    assign w_fa = r_a;
    assign w_fb = r_b;

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) w_next_state = UNPACK;
            end
            UNPACK: w_next_state = ALIGN;
            ALIGN:  w_next_state = ADD;
            ADD:    w_next_state = NORM;
            NORM:   w_next_state = PACK;
            PACK:   w_next_state = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------ alignment
    logic                w_a_big;
    logic [7:0]          w_ex, w_ey, w_diff;
    logic [23:0]         w_mx, w_my;
    logic [c_SIG_W-1:0]  w_sigy_full, w_sigy_sh;

    // Ties pick a, so equal magnitudes subtract to an exact zero.
    assign w_a_big     = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_ex        = w_a_big ? r_ea : r_eb;
    assign w_ey        = w_a_big ? r_eb : r_ea;
    assign w_mx        = w_a_big ? r_ma : r_mb;
    assign w_my        = w_a_big ? r_mb : r_ma;
    assign w_diff      = w_ex - w_ey;
    assign w_sigy_full = {w_my, {GUARD{1'b0}}};
    assign w_sigy_sh   = (w_diff >= c_SHIFT_MAX) ? '0 : (w_sigy_full >> w_diff);

    // ---------------------------------------------------- add/subtract
    logic [c_NRM_W-1:0] w_sum;
    assign w_sum = (r_sx == r_sy) ? ({1'b0, r_sigx} + {1'b0, r_sigy})
                                  : ({1'b0, r_sigx} - {1'b0, r_sigy});

    // --------------------------------------------------- normalization
    logic [c_CW-1:0]    w_lz, w_shift;
    logic [c_NRM_W-1:0] w_nsig;
    logic signed [9:0]  w_nexp;

    fp_lzc #(
        .WIDTH (c_NRM_W)
    ) u_lzc (
        .i_value (r_sum),
        .o_count (w_lz)
    );

    // Normalized leading one sits one below the carry bit, hence lz-1.
    assign w_shift = w_lz - c_CW'(1);

    always_comb begin
        w_nsig = r_sum << w_shift;
        w_nexp = $signed({2'b00, r_rexp}) - $signed(10'(w_shift));
        if (r_sum[c_NRM_W-1]) begin
            w_nsig = r_sum >> 1;
            w_nexp = $signed({2'b00, r_rexp}) + 10'sd1;
        end
    end

    // ------------------------------------------------------------ pack
    logic [31:0] w_pack_res;
    logic [2:0]  w_pack_flags;

    always_comb begin
        w_pack_res   = {r_rs, r_nexp[7:0], r_nsig[c_NRM_W-3 -: 23]};
        w_pack_flags = 3'b000;
        if (r_nzero) begin
            w_pack_res = 32'h0000_0000;
        end else if (r_nexp >= 10'sd255) begin
            w_pack_res   = {r_rs, POS_INF[30:0]};
            w_pack_flags = 3'b010;
        end else if (r_nexp <= 10'sd0) begin
            w_pack_res   = {r_rs, 31'b0};
            w_pack_flags = 3'b001;
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{r_nsig[c_NRM_W-1 -: 2], r_nsig[GUARD-1:0]};

    // ------------------------------------------------- special operands
`ifdef FP_ADDSUB_SPECIAL_EN
    logic        r_spec, r_spec_inv;
    logic [31:0] r_spec_res;
    logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sb_eff;
    logic        w_spec, w_spec_inv;
    logic [31:0] w_spec_res;

    assign w_sb_eff = w_fb.sign ^ r_op;
    assign w_a_inf  = (w_fa.exp == 8'hFF) && (w_fa.mant == '0);
    assign w_b_inf  = (w_fb.exp == 8'hFF) && (w_fb.mant == '0);
    assign w_a_nan  = (w_fa.exp == 8'hFF) && (w_fa.mant != '0);
    assign w_b_nan  = (w_fb.exp == 8'hFF) && (w_fb.mant != '0);
    assign w_spec   = (w_fa.exp == 8'hFF) || (w_fb.exp == 8'hFF);

    always_comb begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_fa.sign != w_sb_eff))) begin
            w_spec_inv = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end else if (w_b_inf) begin
            w_spec_res = {w_sb_eff, POS_INF[30:0]};
        end
    end
`endif

    // -------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= op;
                    end
                end
                UNPACK: begin
                    r_sa <= w_fa.sign;
                    r_sb <= w_fb.sign ^ r_op;
                    r_ea <= w_fa.exp;
                    r_eb <= w_fb.exp;
                    r_ma <= {(w_fa.exp != 8'h00), w_fa.mant};
                    r_mb <= {(w_fb.exp != 8'h00), w_fb.mant};
`ifdef FP_ADDSUB_SPECIAL_EN
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_inv <= w_spec_inv;
`endif
                end
                ALIGN: begin
                    r_sx   <= w_a_big ? r_sa : r_sb;
                    r_sy   <= w_a_big ? r_sb : r_sa;
                    r_ex   <= w_ex;
                    r_sigx <= {w_mx, {GUARD{1'b0}}};
                    r_sigy <= w_sigy_sh;
                end
                ADD: begin
                    r_sum  <= w_sum;
                    r_rs   <= r_sx;
                    r_rexp <= r_ex;
                end
                NORM: begin
                    r_nsig  <= w_nsig;
                    r_nexp  <= w_nexp;
                    r_nzero <= (r_sum == '0);
                end
                PACK: begin
`ifdef FP_ADDSUB_SPECIAL_EN
                    if (r_spec) begin
                        r_result <= r_spec_res;
                        r_flags  <= {r_spec_inv, 2'b00};
                    end else begin
                        r_result <= w_pack_res;
                        r_flags  <= w_pack_flags;
                    end
`else
                    r_result <= w_pack_res;
                    r_flags  <= w_pack_flags;
`endif
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

`default_nettype wire

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameter GUARD, default 3: extra LSBs kept below the 24-bit significand through align/add/normalize.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/op is presented.
REQ-005 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-006 a, b  input  32 each  IEEE-754 single operands.
REQ-007 op  input  1  0 = a+b, 1 = a-b (b sign inverted).
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  32  IEEE-754 single result.
REQ-011 flags  output  3  {invalid, overflow, underflow}.

Function
REQ-012 FSM states SHALL be IDLE, UNPACK, ALIGN, ADD, NORM, PACK, HOLD.
REQ-013 IDLE->UNPACK on in_valid&&in_ready; a, b, op captured that edge; inputs ignored afterward until IDLE.
REQ-014 UNPACK: split sign/exp/mantissa; hidden bit 1 if exp!=0, else 0 (denormal); effective sign_b = b[31]^op.
REQ-015 ALIGN: larger-magnitude operand (exp, then mantissa) becomes X; other operand's significand shifted right by exp difference; shifts >= 24+GUARD give zero; result exponent = X exp.
REQ-016 ADD: same effective signs -> add significands; else subtract smaller from X (never negative); result sign = X sign.
REQ-017 NORM: carry-out -> shift right 1, exp+1; otherwise leading-zero count, shift left, exp decremented, single cycle; zero significand -> result +0 (0x00000000).
REQ-018 PACK: truncate guard bits (round toward zero); exp >= 255 -> ±inf (mantissa 0), overflow=1; exp <= 0 -> ±0, underflow=1.
REQ-019 Fixed latency: out_valid asserts exactly 5 cycles after accept edge (UNPACK..PACK one cycle each), entering HOLD.
REQ-020 HOLD: out_valid=1, result/flags stable until out_ready high; that edge -> IDLE; in_ready returns next cycle (no same-cycle back-to-back accept).
REQ-021 out_ready ignored outside HOLD; in_valid ignored outside IDLE.

Reset
REQ-022 rst_n low at clock edge -> IDLE regardless of state; in-flight operation discarded, no out_valid.
REQ-023 Reset values: in_ready=1 after reset released (0 while rst_n low), out_valid=0, result=0, flags=0.

Configuration
REQ-024 Macro FP_ADDSUB_SPECIAL_EN defined: exp=255 inputs treated as inf/NaN; NaN input or inf-inf -> 0x7FC00000, invalid=1; inf ± finite -> that inf; latency unchanged.
REQ-025 Macro undefined: exp=255 treated as ordinary exponent, invalid tied 0, special-case logic absent.

Structure
REQ-026 Package fp_pkg holds state enum type, fp32 struct (sign, exp[7:0], mant[22:0]), constants QNAN=0x7FC00000, POS_INF=0x7F800000, BIAS=127.
REQ-027 One sub-module fp_lzc: combinational leading-zero counter for (24+GUARD+1)-bit significand, used in NORM.

Verification
REQ-028 a=0x40400000, b=0x3F800000, op=1 -> result 0x40000000, flags 0, out_valid 5 cycles after accept.
REQ-029 a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000; op=0 -> 0x40000000.
REQ-030 a=b=0x7F7FFFFF, op=0 -> result 0x7F800000, overflow=1.
REQ-031 out_ready low 4 cycles in HOLD -> result/out_valid held, in_ready=0, new in_valid not captured; accept once out_ready=1.
REQ-032 rst_n low during ALIGN -> next cycle IDLE, out_valid never asserts for that op; next op 0x3F800000+0x3F800000 -> 0x40000000.
REQ-033 With FP_ADDSUB_SPECIAL_EN: a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, invalid=1.
